// File: rtl/dpram_arbiter.sv
// Two-requester arbiter in front of a single-port-per-direction RAM: independent write and read
// channels with round-robin on contention, a two-stage read pipeline and a write-first bypass.
module dpram_arbiter #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          enb,
    output logic          wr,
    output logic          rd,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] r_addr,
    output logic [DW-1:0] w_data,
    input  logic [DW-1:0] r_data
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    pri_e          wr_pri_q, wr_pri_d;
    pri_e          rd_pri_q, rd_pri_d;

    logic          a_wreq, b_wreq, a_rreq, b_rreq;
    logic          a_wgnt, b_wgnt, a_rgnt, b_rgnt;

    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          rd_src_q, rd_src_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [AW-1:0] r_addr_q, r_addr_d;
    logic [DW-1:0] w_data_q, w_data_d;

    logic          rvld_q, rvld_d;
    logic          rsrc_q, rsrc_d;
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;

    logic [DW-1:0] rdata_mux;

    // Arbitration: requests are masked during reset so grants and pointers stay frozen.
    always_comb begin
        a_wreq = a_req & a_wr & ~rstn;
        b_wreq = b_req & b_wr & ~rstn;
        a_rreq = a_req & ~a_wr & ~rstn;
        b_rreq = b_req & ~b_wr & ~rstn;

        a_wgnt = a_wreq & (~b_wreq | (wr_pri_q == PRI_A));
        b_wgnt = b_wreq & (~a_wreq | (wr_pri_q == PRI_B));
        a_rgnt = a_rreq & (~b_rreq | (rd_pri_q == PRI_A));
        b_rgnt = b_rreq & (~a_rreq | (rd_pri_q == PRI_B));

        a_gnt  = a_wgnt | a_rgnt;
        b_gnt  = b_wgnt | b_rgnt;

        wr_pri_d = wr_pri_q;
        if (a_wreq && b_wreq) begin
            wr_pri_d = a_wgnt ? PRI_B : PRI_A;
        end
        rd_pri_d = rd_pri_q;
        if (a_rreq && b_rreq) begin
            rd_pri_d = a_rgnt ? PRI_B : PRI_A;
        end
    end

    // Stage 1: accepted commands become RAM strobes on the following cycle.
    always_comb begin
        wr_d     = a_wgnt | b_wgnt;
        rd_d     = a_rgnt | b_rgnt;
        rd_src_d = b_rgnt;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        r_addr_d = r_addr_q;
        if (wr_d) begin
            w_addr_d = a_wgnt ? a_addr : b_addr;
            w_data_d = a_wgnt ? a_wdata : b_wdata;
        end
        if (rd_d) begin
            r_addr_d = a_rgnt ? a_addr : b_addr;
        end
    end

    // Stage 2: response tag plus a captured write word when the same RAM cycle hit one address.
    always_comb begin
        rvld_d     = rd_q;
        rsrc_d     = rd_src_q;
        byp_d      = wr_q & rd_q & (w_addr_q == r_addr_q);
        byp_data_d = w_data_q;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_pri_q <= PRI_A;
            rd_pri_q <= PRI_A;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd_src_q <= 1'b0;
            rvld_q   <= 1'b0;
            rsrc_q   <= 1'b0;
            byp_q    <= 1'b0;
        end else begin
            wr_pri_q <= wr_pri_d;
            rd_pri_q <= rd_pri_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rd_src_q <= rd_src_d;
            rvld_q   <= rvld_d;
            rsrc_q   <= rsrc_d;
            byp_q    <= byp_d;
        end
    end

    always_ff @(posedge clk) begin
        w_addr_q   <= w_addr_d;
        w_data_q   <= w_data_d;
        r_addr_q   <= r_addr_d;
        byp_data_q <= byp_data_d;
    end

    // Outputs are qualified by their valid flags and by reset so idle/reset cycles drive zeros.
    always_comb begin
        wr        = wr_q & ~rstn;
        rd        = rd_q & ~rstn;
        enb       = wr | rd;
        w_addr    = wr ? w_addr_q : '0;
        w_data    = wr ? w_data_q : '0;
        r_addr    = rd ? r_addr_q : '0;

        rdata_mux = byp_q ? byp_data_q : r_data;
        a_rvalid  = rvld_q & ~rsrc_q & ~rstn;
        b_rvalid  = rvld_q & rsrc_q & ~rstn;
        a_rdata   = a_rvalid ? rdata_mux : '0;
        b_rdata   = b_rvalid ? rdata_mux : '0;
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a scheduled-event model of grants, RAM strobes and responses.
module tb_dpram_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          a_req, a_wr, b_req, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          enb, wr, rd;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] w_data, r_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .enb(enb), .wr(wr), .rd(rd), .w_addr(w_addr), .r_addr(r_addr),
        .w_data(w_data), .r_data(r_data)
    );

    // RAM: read returns the pre-write contents, so same-address hazards rely on the bypass.
    logic [DW-1:0] ram [1<<AW];
    bit            ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(i);
            ram_init <= 1'b1;
            r_data   <= DW'($urandom);
        end else begin
            if (wr) ram[w_addr] <= w_data;
            if (rd) r_data <= ram[r_addr];
            else    r_data <= DW'($urandom);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            due;
        bit            is_wr;
        bit            src_b;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;
    typedef struct {
        int            due;
        bit            src_b;
        logic [DW-1:0] data;
    } rsp_t;

    op_t           ops[$];
    rsp_t          rsps[$];
    logic [DW-1:0] ref_mem [1<<AW];

    initial begin : model
        int cyc;
        bit wpri_b, rpri_b;
        cyc = 0;
        wpri_b = 1'b0;
        rpri_b = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i);
        forever begin
            logic          e_wr, e_rd, e_ag, e_bg, e_arv, e_brv;
            logic [AW-1:0] e_wa, e_ra;
            logic [DW-1:0] e_wd, e_ard, e_brd;
            bit            aw, bw, ar, br, wga, wgb, rga, rgb;
            @(negedge clk);
            e_wr = 0; e_rd = 0; e_ag = 0; e_bg = 0; e_arv = 0; e_brv = 0;
            e_wa = '0; e_ra = '0; e_wd = '0; e_ard = '0; e_brd = '0;
            if (rstn) begin
                ops.delete();
                rsps.delete();
                wpri_b = 1'b0;
                rpri_b = 1'b0;
            end else begin
                foreach (ops[i]) if (ops[i].due == cyc && ops[i].is_wr) begin
                    e_wr = 1; e_wa = ops[i].addr; e_wd = ops[i].data;
                    ref_mem[ops[i].addr] = ops[i].data;
                end
                foreach (ops[i]) if (ops[i].due == cyc && !ops[i].is_wr) begin
                    e_rd = 1; e_ra = ops[i].addr;
                    rsps.push_back('{cyc + 1, ops[i].src_b, ref_mem[ops[i].addr]});
                end
                while (ops.size() > 0 && ops[0].due <= cyc) void'(ops.pop_front());
                foreach (rsps[i]) if (rsps[i].due == cyc) begin
                    if (rsps[i].src_b) begin e_brv = 1; e_brd = rsps[i].data; end
                    else begin e_arv = 1; e_ard = rsps[i].data; end
                end
                while (rsps.size() > 0 && rsps[0].due <= cyc) void'(rsps.pop_front());

                aw = a_req & a_wr;  bw = b_req & b_wr;
                ar = a_req & !a_wr; br = b_req & !b_wr;
                wga = aw && (!bw || !wpri_b); wgb = bw && !wga;
                rga = ar && (!br || !rpri_b); rgb = br && !rga;
                if (aw && bw) wpri_b = wga;
                if (ar && br) rpri_b = rga;
                e_ag = wga | rga;
                e_bg = wgb | rgb;
                if (wga) ops.push_back('{cyc + 1, 1'b1, 1'b0, a_addr, a_wdata});
                if (wgb) ops.push_back('{cyc + 1, 1'b1, 1'b1, b_addr, b_wdata});
                if (rga) ops.push_back('{cyc + 1, 1'b0, 1'b0, a_addr, '0});
                if (rgb) ops.push_back('{cyc + 1, 1'b0, 1'b1, b_addr, '0});
            end
            chk("m_a_gnt",    32'(a_gnt),    32'(e_ag));
            chk("m_b_gnt",    32'(b_gnt),    32'(e_bg));
            chk("m_enb",      32'(enb),      32'(e_wr | e_rd));
            chk("m_wr",       32'(wr),       32'(e_wr));
            chk("m_rd",       32'(rd),       32'(e_rd));
            chk("m_w_addr",   32'(w_addr),   32'(e_wa));
            chk("m_w_data",   32'(w_data),   32'(e_wd));
            chk("m_r_addr",   32'(r_addr),   32'(e_ra));
            chk("m_a_rvalid", 32'(a_rvalid), 32'(e_arv));
            chk("m_a_rdata",  32'(a_rdata),  32'(e_ard));
            chk("m_b_rvalid", 32'(b_rvalid), 32'(e_brv));
            chk("m_b_rdata",  32'(b_rdata),  32'(e_brd));
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic ag, bg;
        rstn = 1; a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;

        tick();
        a_req = 1; a_wr = 1; a_addr = 4'd3; a_wdata = 8'h5A;
        @(negedge clk);
        chk("rst_a_gnt", 32'(a_gnt), 0);
        chk("rst_enb", 32'(enb), 0);
        chk("rst_a_rvalid", 32'(a_rvalid), 0);

        tick();
        rstn = 0;
        @(negedge clk);
        chk("first_accept_gnt", 32'(a_gnt), 1);
        tick();
        a_wr = 0;
        @(negedge clk);
        chk("wr_strobe", 32'(wr), 1);
        chk("wr_enb", 32'(enb), 1);
        chk("wr_addr", 32'(w_addr), 3);
        chk("wr_data", 32'(w_data), 32'h5A);
        chk("rd_accept", 32'(a_gnt), 1);
        tick();
        a_req = 0;
        @(negedge clk);
        chk("rd_strobe", 32'(rd), 1);
        chk("rd_addr", 32'(r_addr), 3);
        chk("wr_idle", 32'(wr), 0);
        tick();
        @(negedge clk);
        chk("a_rvalid_5a", 32'(a_rvalid), 1);
        chk("a_rdata_5a", 32'(a_rdata), 32'h5A);

        for (int i = 0; i < 4; i++) begin
            tick();
            a_req = 1; a_wr = 1; a_addr = 4'd8; a_wdata = 8'hA0;
            b_req = 1; b_wr = 1; b_addr = 4'd9; b_wdata = 8'hB0;
            @(negedge clk);
            chk("alt_a_gnt", 32'(a_gnt), (i % 2 == 0) ? 1 : 0);
            chk("alt_b_gnt", 32'(b_gnt), (i % 2 == 0) ? 0 : 1);
        end

        tick();
        a_req = 1; a_wr = 1; a_addr = 4'd7; a_wdata = 8'h11;
        b_req = 1; b_wr = 0; b_addr = 4'd7;
        @(negedge clk);
        chk("haz_a_gnt", 32'(a_gnt), 1);
        chk("haz_b_gnt", 32'(b_gnt), 1);
        tick();
        a_req = 0; b_req = 0;
        @(negedge clk);
        chk("haz_wr", 32'(wr), 1);
        chk("haz_rd", 32'(rd), 1);
        tick();
        @(negedge clk);
        chk("haz_b_rvalid", 32'(b_rvalid), 1);
        chk("haz_b_rdata", 32'(b_rdata), 32'h11);
        chk("haz_a_rvalid", 32'(a_rvalid), 0);

        tick();
        a_req = 1; a_wr = 1; a_addr = 4'd3; a_wdata = 8'h03;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tick();
            a_wr = 0;
            a_req = (k < 3);
            a_addr = AW'(k + 1);
            @(negedge clk);
            if (k >= 2) begin
                chk("burst_a_rvalid", 32'(a_rvalid), 1);
                chk("burst_a_rdata", 32'(a_rdata), k - 1);
            end
            chk("burst_b_rvalid", 32'(b_rvalid), 0);
        end

        tick();
        a_req = 1; a_wr = 0; a_addr = 4'd1;
        b_req = 1; b_wr = 0; b_addr = 4'd2;
        @(negedge clk);
        chk("pre_rst_a_gnt", 32'(a_gnt), 1);
        chk("pre_rst_b_gnt", 32'(b_gnt), 0);
        tick();
        a_req = 0;
        @(negedge clk);
        chk("pre_rst_b_gnt2", 32'(b_gnt), 1);
        tick();
        rstn = 1; b_req = 0;
        @(negedge clk);
        chk("mid_rst_enb", 32'(enb), 0);
        chk("mid_rst_rd", 32'(rd), 0);
        chk("mid_rst_r_addr", 32'(r_addr), 0);
        chk("mid_rst_a_rvalid", 32'(a_rvalid), 0);
        tick();
        rstn = 0;
        a_req = 1; a_wr = 0; a_addr = 4'd4;
        b_req = 1; b_wr = 0; b_addr = 4'd5;
        @(negedge clk);
        chk("post_rst_b_rvalid", 32'(b_rvalid), 0);
        chk("post_rst_a_gnt", 32'(a_gnt), 1);
        chk("post_rst_b_gnt", 32'(b_gnt), 0);
        tick();
        a_req = 0;
        @(negedge clk);
        chk("post_rst_b_gnt2", 32'(b_gnt), 1);
        chk("post_rst_b_rvalid2", 32'(b_rvalid), 0);
        tick();
        b_req = 0;
        @(negedge clk);
        chk("post_rst_a_rdata", 32'(a_rdata), 4);
        tick();
        @(negedge clk);
        chk("post_rst_b_rdata", 32'(b_rdata), 5);

        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("idle_enb", 32'(enb), 0);
            chk("idle_wr_rd", 32'({wr, rd}), 0);
            chk("idle_gnt", 32'({a_gnt, b_gnt}), 0);
            chk("idle_rvalid", 32'({a_rvalid, b_rvalid}), 0);
        end

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ag = a_gnt;
            bg = b_gnt;
            @(posedge clk);
            #1;
            if (rstn) rstn = 0;
            else if ($urandom_range(0, 99) == 0) rstn = 1;
            if (!a_req || ag) begin
                a_req   = ($urandom_range(0, 9) < 7);
                a_wr    = $urandom_range(0, 1) == 1;
                a_addr  = $urandom_range(0, 1) == 1 ? AW'($urandom_range(0, 3)) : AW'($urandom);
                a_wdata = DW'($urandom);
            end
            if (!b_req || bg) begin
                b_req   = ($urandom_range(0, 9) < 7);
                b_wr    = $urandom_range(0, 1) == 1;
                b_addr  = $urandom_range(0, 1) == 1 ? AW'($urandom_range(0, 3)) : AW'($urandom);
                b_wdata = DW'($urandom);
            end
        end

        tick();
        a_req = 0; b_req = 0;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
